// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, grant encoding
// and the byte-enable pattern used for instruction fetches.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_F    = 2'd1,
    GNT_D    = 2'd2
  } grant_e;

  localparam logic [3:0] FETCH_BE = 4'hF;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch port, data port, stall outputs and external memory bus.
// The arbiter uses the slave modport; the core/memory side uses master.
interface mem_arbiter_if #(parameter int AW = 32);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ready;
  logic [31:0]   if_rdata;

  logic          d_req;
  logic          d_we;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_ready;
  logic [31:0]   d_rdata;

  logic          stall_f;
  logic          stall_m;

  logic          mem_en;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic [31:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_ack, mem_rdata,
    output if_ready, if_rdata, d_ready, d_rdata, stall_f, stall_m,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_ack, mem_rdata,
    input  if_ready, if_rdata, d_ready, d_rdata, stall_f, stall_m,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_streak.sv
// Saturating count of consecutive data grants made while fetch waits;
// raises o_forced once fetch has been passed over MAX_D_STREAK times.
module mem_arb_streak #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  input  logic i_if_req,
  output logic o_forced
);

  localparam int W = $clog2(MAX_D_STREAK + 1);
  localparam logic [W-1:0] MAX_V = W'(MAX_D_STREAK);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_count <= '0;
    else if (i_clr)
      r_count <= '0;
    else if (i_inc && (r_count != MAX_V))
      r_count <= r_count + W'(1);
  end

  assign o_forced = i_if_req && (r_count == MAX_V);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch and data ports. Data wins ties
// unless fetch has been starved for MAX_D_STREAK consecutive data grants.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = 4,
  parameter int AW           = 32
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);

  state_e        r_state;
  state_e        w_next;
  grant_e        w_grant;
  logic          w_forced;
  logic          w_inc;
  logic          w_clr;
  logic          w_if_ready;
  logic          w_d_ready;

  logic          r_we;
  logic [3:0]    r_be;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_grant = GNT_NONE;
    case (r_state)
      IDLE: begin
        if (bus.d_req && !w_forced) begin
          w_next  = BUSY_D;
          w_grant = GNT_D;
        end else if (bus.if_req) begin
          w_next  = BUSY_F;
          w_grant = GNT_F;
        end
      end
      BUSY_F, BUSY_D: begin
        if (bus.mem_ack)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_inc = (w_grant == GNT_D) && bus.if_req;
  assign w_clr = (w_grant == GNT_F) || ((r_state == IDLE) && !bus.if_req);

  mem_arb_streak #(.MAX_D_STREAK(MAX_D_STREAK)) u_streak (
    .clk      (clk),
    .rst      (rst),
    .i_inc    (w_inc),
    .i_clr    (w_clr),
    .i_if_req (bus.if_req),
    .o_forced (w_forced)
  );

  // Memory command is latched at grant and cleared once the access finishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_grant == GNT_D) begin
      r_we    <= bus.d_we;
      r_be    <= bus.d_be;
      r_addr  <= bus.d_addr;
      r_wdata <= bus.d_wdata;
    end else if (w_grant == GNT_F) begin
      r_we    <= 1'b0;
      r_be    <= FETCH_BE;
      r_addr  <= bus.if_addr;
      r_wdata <= '0;
    end else if ((r_state != IDLE) && bus.mem_ack) begin
      r_we    <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end
  end

  assign bus.mem_en    = (r_state != IDLE);
  assign bus.mem_we    = r_we;
  assign bus.mem_be    = r_be;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;

  // A requester that dropped its request mid-access gets no ready pulse.
  assign w_if_ready   = (r_state == BUSY_F) && bus.mem_ack && bus.if_req;
  assign w_d_ready    = (r_state == BUSY_D) && bus.mem_ack && bus.d_req;
  assign bus.if_ready = w_if_ready;
  assign bus.d_ready  = w_d_ready;
  assign bus.if_rdata = w_if_ready ? bus.mem_rdata : 32'h0;
  assign bus.d_rdata  = (w_d_ready && !r_we) ? bus.mem_rdata : 32'h0;

  assign bus.stall_f = !rst && bus.if_req && !w_if_ready;
  assign bus.stall_m = !rst && bus.d_req && !w_d_ready;

endmodule
